// File: rtl/tt_lut_pkg.sv
// tt_lut_pkg: shared types and sizing helpers for the truth-table evaluator
package tt_lut_pkg;
  localparam int TT_W_MAX = 256;
  typedef enum logic [1:0] {IDLE, LOAD, SWEEP} state_t;
  function automatic int nwords(input int tt_w, input int cfg_w);
    return (tt_w + cfg_w - 1) / cfg_w;
  endfunction
endpackage

// File: rtl/tt_out_reg.sv
// tt_out_reg: one-entry valid/ready output register for result bit and vector
module tt_out_reg #(
  parameter int N_IN = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            d_bit,
  input  logic [N_IN-1:0] d_vec,
  input  logic            out_ready,
  output logic            out_valid,
  output logic            out_bit,
  output logic [N_IN-1:0] out_vec
);
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_bit <= 1'b0;
      out_vec <= '0;
    end else if (push) begin
      out_valid <= 1'b1;
      out_bit <= d_bit;
      out_vec <= d_vec;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/tt_lut_evaluator.sv
// tt_lut_evaluator: programmable N-input truth table with streaming eval and self-check sweep
module tt_lut_evaluator
  import tt_lut_pkg::*;
#(
  parameter int N_IN = 3,
  parameter int CFG_W = 8,
  localparam int TT_W = 2 ** N_IN,
  parameter logic [TT_W-1:0] RESET_TT = 'h76
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [CFG_W-1:0] cfg_word,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N_IN-1:0] in_vec,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_bit,
  output logic [N_IN-1:0] out_vec,
  input  logic [TT_W-1:0] golden_tt,
  input  logic            sweep_start,
  output logic            sweep_busy,
  output logic            sweep_done,
  output logic [N_IN:0]   sweep_mismatch
);
  localparam int NWORDS = nwords(TT_W, CFG_W);
  localparam int WC_W = NWORDS > 1 ? $clog2(NWORDS) : 1;
  localparam int IW = N_IN + 1;
  state_t state, state_nx;
  logic [TT_W-1:0] tt;
  logic [NWORDS*CFG_W-1:0] shadow, shadow_nx;
  logic [WC_W-1:0] wcnt;
  logic [IW-1:0] idx, acc;
  logic cfg_acc, last_word, sweep_go, sweep_last, push, miss;
  always_comb begin
    shadow_nx = shadow;
    shadow_nx[int'(wcnt)*CFG_W +: CFG_W] = cfg_word;
    cfg_ready = state != SWEEP;
    in_ready = state == IDLE && (!out_valid || out_ready);
    sweep_busy = state == SWEEP;
    cfg_acc = cfg_valid && cfg_ready;
    last_word = cfg_acc && wcnt == WC_W'(NWORDS - 1);
    sweep_go = state == IDLE && !cfg_valid && sweep_start && !out_valid;
    sweep_last = state == SWEEP && idx == IW'(TT_W - 1);
    push = in_valid && in_ready;
    miss = tt[idx[N_IN-1:0]] ^ golden_tt[idx[N_IN-1:0]];
    state_nx = last_word ? IDLE : cfg_acc ? LOAD : sweep_go ? SWEEP : sweep_last ? IDLE : state;
  end
  // the shadow absorbs partial loads so the live table only changes on the final word
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tt <= RESET_TT;
      shadow <= '0;
      wcnt <= '0;
      idx <= '0;
      acc <= '0;
      sweep_done <= 1'b0;
      sweep_mismatch <= '0;
    end else begin
      state <= state_nx;
      sweep_done <= sweep_last;
      if (cfg_acc) begin
        shadow <= shadow_nx;
        wcnt <= last_word ? '0 : wcnt + 1'b1;
      end
      if (last_word) tt <= shadow_nx[TT_W-1:0];
      if (sweep_go) begin
        idx <= '0;
        acc <= '0;
        sweep_mismatch <= '0;
      end else if (sweep_busy) begin
        idx <= idx + 1'b1;
        acc <= acc + IW'(miss);
      end
      if (sweep_last) sweep_mismatch <= acc + IW'(miss);
    end
  end
  tt_out_reg #(.N_IN(N_IN)) u_out (
    .clk(clk), .rst(rst), .push(push), .d_bit(tt[in_vec]), .d_vec(in_vec),
    .out_ready(out_ready), .out_valid(out_valid), .out_bit(out_bit), .out_vec(out_vec)
  );
endmodule

// File: tb/tb_tt_lut_evaluator.sv
// tb_tt_lut_evaluator: directed checks of evaluation, config load and sweep
module tb_tt_lut_evaluator;
  logic clk = 1'b0, rst = 1'b1;
  logic cfg_valid = 0, cfg_ready, in_valid = 0, in_ready, out_valid, out_ready = 1, out_bit;
  logic [7:0] cfg_word = '0, golden_tt = '0;
  logic [2:0] in_vec = '0, out_vec;
  logic sweep_start = 0, sweep_busy, sweep_done;
  logic [3:0] sweep_mismatch;
  logic b_cfg_valid = 0, b_cfg_ready, b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 1, b_out_bit;
  logic [7:0] b_cfg_word = '0;
  logic [15:0] b_golden_tt = '0;
  logic [3:0] b_in_vec = '0, b_out_vec;
  logic b_sweep_start = 0, b_sweep_busy, b_sweep_done;
  logic [4:0] b_sweep_mismatch;
  int total = 0, passed = 0, failed = 0;
  logic exp_bits [8] = '{0, 1, 1, 0, 1, 1, 1, 0};

  tt_lut_evaluator dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_word(cfg_word),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec), .out_valid(out_valid),
    .out_ready(out_ready), .out_bit(out_bit), .out_vec(out_vec), .golden_tt(golden_tt),
    .sweep_start(sweep_start), .sweep_busy(sweep_busy), .sweep_done(sweep_done),
    .sweep_mismatch(sweep_mismatch)
  );

  tt_lut_evaluator #(.N_IN(4), .CFG_W(8), .RESET_TT(16'hA5C3)) dut_b (
    .clk(clk), .rst(rst), .cfg_valid(b_cfg_valid), .cfg_ready(b_cfg_ready), .cfg_word(b_cfg_word),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_vec(b_in_vec), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_bit(b_out_bit), .out_vec(b_out_vec), .golden_tt(b_golden_tt),
    .sweep_start(b_sweep_start), .sweep_busy(b_sweep_busy), .sweep_done(b_sweep_done),
    .sweep_mismatch(b_sweep_mismatch)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sweep_a(input logic [7:0] g, input int exp_mm);
    int n;
    golden_tt = g;
    sweep_start = 1;
    tick();
    sweep_start = 0;
    chk("a_busy", sweep_busy, 1);
    chk("a_cfg_ready_sweep", cfg_ready, 0);
    chk("a_in_ready_sweep", in_ready, 0);
    chk("a_mm_clear", sweep_mismatch, 0);
    n = 1;
    while (!sweep_done && n < 40) begin
      tick();
      n++;
    end
    chk("a_done_cycle", n, 9);
    chk("a_mm", sweep_mismatch, exp_mm);
    chk("a_idle_after", sweep_busy, 0);
    tick();
    chk("a_done_pulse", sweep_done, 0);
    chk("a_mm_hold", sweep_mismatch, exp_mm);
  endtask

  task automatic sweep_b(input logic [15:0] g, input int exp_mm);
    int n;
    b_golden_tt = g;
    b_sweep_start = 1;
    tick();
    b_sweep_start = 0;
    chk("b_busy", b_sweep_busy, 1);
    n = 1;
    while (!b_sweep_done && n < 60) begin
      tick();
      n++;
    end
    chk("b_done_cycle", n, 17);
    chk("b_mm", b_sweep_mismatch, exp_mm);
  endtask

  initial begin
    int seen;
    tick();
    tick();
    rst = 0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_bit", out_bit, 0);
    chk("rst_out_vec", out_vec, 0);
    chk("rst_busy", sweep_busy, 0);
    chk("rst_done", sweep_done, 0);
    chk("rst_mm", sweep_mismatch, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_in_ready", in_ready, 1);
    in_valid = 1;
    for (int v = 0; v < 8; v++) begin
      in_vec = 3'(v);
      tick();
      chk("stream_valid", out_valid, 1);
      chk("stream_bit", out_bit, exp_bits[v]);
      chk("stream_vec", out_vec, v);
    end
    in_valid = 0;
    tick();
    chk("stream_drain", out_valid, 0);
    sweep_a(8'h76, 0);
    sweep_a(8'h00, 5);
    cfg_valid = 1;
    cfg_word = 8'h96;
    tick();
    cfg_valid = 0;
    chk("load_idle", in_ready, 1);
    sweep_a(8'h76, 3);
    in_valid = 1;
    in_vec = 3;
    tick();
    chk("new_tt_v3", out_bit, 0);
    in_vec = 4;
    tick();
    chk("new_tt_v4", out_bit, 1);
    cfg_valid = 1;
    cfg_word = 8'h76;
    in_vec = 7;
    tick();
    cfg_valid = 0;
    chk("commit_old_tt", out_bit, 1);
    tick();
    chk("commit_new_tt", out_bit, 0);
    in_valid = 0;
    tick();
    out_ready = 0;
    in_valid = 1;
    in_vec = 1;
    tick();
    in_vec = 2;
    chk("hold_valid", out_valid, 1);
    chk("hold_bit", out_bit, 1);
    chk("hold_in_ready", in_ready, 0);
    sweep_start = 1;
    tick();
    sweep_start = 0;
    chk("hold_vec", out_vec, 1);
    chk("hold_bit2", out_bit, 1);
    chk("sweep_dropped", sweep_busy, 0);
    out_ready = 1;
    #1;
    chk("release_in_ready", in_ready, 1);
    tick();
    chk("release_vec", out_vec, 2);
    chk("release_bit", out_bit, 1);
    in_valid = 0;
    tick();
    chk("release_drain", out_valid, 0);
    cfg_valid = 1;
    cfg_word = 8'h76;
    sweep_start = 1;
    tick();
    cfg_valid = 0;
    sweep_start = 0;
    chk("tie_no_busy", sweep_busy, 0);
    chk("tie_cfg_ready", cfg_ready, 1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (sweep_done || sweep_busy) seen++;
      tick();
    end
    chk("tie_no_done", seen, 0);
    b_cfg_valid = 1;
    b_cfg_word = 8'hFF;
    tick();
    b_cfg_valid = 0;
    chk("b_load_in_ready", b_in_ready, 0);
    chk("b_load_cfg_ready", b_cfg_ready, 1);
    rst = 1;
    tick();
    rst = 0;
    chk("b_rst_idle", b_in_ready, 1);
    chk("a_rst_mm", sweep_mismatch, 0);
    sweep_b(16'hA5C3, 0);
    sweep_b(16'h0000, 8);
    b_cfg_valid = 1;
    b_cfg_word = 8'hFF;
    tick();
    chk("b_word1_load", b_in_ready, 0);
    b_cfg_word = 8'h00;
    tick();
    b_cfg_valid = 0;
    chk("b_word2_idle", b_in_ready, 1);
    b_in_valid = 1;
    b_in_vec = 0;
    tick();
    chk("b_v0", b_out_bit, 1);
    b_in_vec = 8;
    tick();
    chk("b_v8", b_out_bit, 0);
    b_in_valid = 0;
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
